key_debouncer: RTL and testbench
================================

# key_debouncer

Multi-channel push-button conditioner for the board keys that feed the counter and display datapath. It synchronizes each raw key input to `clk` and filters contact bounce with a per-key stability counter. Its outputs are a clean level plus single-cycle press and release strobes, so downstream logic such as start/pause toggles and counter clears sees exactly one event per physical press. Instantiate it between the pins and any logic that reacts to key edges.

## Interface
- `N_KEYS`, default 2: number of independent key channels.
- `DEBOUNCE_CYCLES`, default 20_000: input must be stable this many consecutive cycles to accept a change (10 ms at 2 MHz). Legal range is ≥ 2.
- `HOLD_CYCLES`, default 2_000_000: press duration that fires the long-press strobe (1 s at 2 MHz). Used only with `KEY_LONG_PRESS_EN`. Legal range is > `DEBOUNCE_CYCLES`.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `key_raw`, input, `N_KEYS`: raw active-high key pins, asynchronous to `clk`.
- `key_level`, output, `N_KEYS`: debounced key state, 1 while the key is accepted as pressed.
- `key_press`, output, `N_KEYS`: one-cycle strobe on an accepted press.
- `key_release`, output, `N_KEYS`: one-cycle strobe on an accepted release.
- `key_long`, output, `N_KEYS`: one-cycle strobe when the hold threshold is reached. Tied to 0 without `KEY_LONG_PRESS_EN`.

## Operation
- Each channel is independent, with no interaction between keys.
- Synchronizer: 2 flops per key. Call the synchronized output `key_sync`.
- Per-channel FSM states: IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT.
- IDLE:
  - When `key_sync`=1, go to PRESS_WAIT with `cnt`=1.
- PRESS_WAIT:
  - While `key_sync`=1, `cnt`++.
  - If `key_sync`=0, go to IDLE and clear `cnt`.
  - When `cnt`==`DEBOUNCE_CYCLES`-1 and `key_sync`=1, go to DOWN. At that transition, set `key_level`←1, pulse `key_press`, and clear `cnt`.
- DOWN:
  - When `key_sync`=0, go to RELEASE_WAIT with `cnt`=1.
- RELEASE_WAIT:
  - While `key_sync`=0, `cnt`++.
  - If `key_sync`=1, go back to DOWN and clear `cnt`. No strobes fire.
  - When `cnt`==`DEBOUNCE_CYCLES`-1 and `key_sync`=0, go to IDLE. At that transition, set `key_level`←0 and pulse `key_release`.
- Strobes:
  - All strobes are registered and last exactly one cycle.
  - `key_press` and `key_release` never assert in the same cycle for the same key.
- Counter widths:
  - `cnt` is $clog2(`DEBOUNCE_CYCLES`) bits.
  - The hold counter is $clog2(`HOLD_CYCLES`) bits.
  - No counter ever wraps. `cnt` is bounded by the FSM, and the hold counter saturates.
- Glitch filtering: a pulse or gap shorter than `DEBOUNCE_CYCLES` cycles at `key_sync` produces no strobe and no `key_level` change.

## Timing
- Reset: all outputs 0, all FSMs in IDLE, counters 0, synchronizer flops 0.
- Press latency: with `key_raw` stable high from the first sampling edge E, `key_level` and `key_press` are 1 in the cycle after edge E+`DEBOUNCE_CYCLES`+1. That is `DEBOUNCE_CYCLES`+2 cycles of latency.
- Release latency: the same, `DEBOUNCE_CYCLES`+2 cycles.
- Minimum spacing between two accepted presses on one key: 2·`DEBOUNCE_CYCLES` cycles.
- Reset mid-debounce or mid-hold: the channel returns to IDLE immediately and asynchronously, with no strobes. A key still held when `rst` drops is re-accepted as a new press after the full press latency.
- Throughput: every channel accepts input every cycle and has no backpressure.

## Configuration
- Macro: `KEY_LONG_PRESS_EN`.
- Defined:
  - A per-channel hold counter runs in DOWN and RELEASE_WAIT and is cleared on entry to IDLE.
  - `key_long` pulses once in the cycle after the hold counter reaches `HOLD_CYCLES`-1, measured from the `key_press` cycle.
  - The hold counter then saturates, so there is at most one `key_long` per press.
  - A bounce into RELEASE_WAIT shorter than `DEBOUNCE_CYCLES` does not restart the hold counter.
- Undefined: no hold counter logic is built, and `key_long` is constant 0.

## Structure
- Package `key_pkg` holds:
  - the typedef enum `key_state_e` {IDLE, PRESS_WAIT, DOWN, RELEASE_WAIT}, 2-bit;
  - the default localparams `KEY_DEBOUNCE_DEFAULT` = 20_000 and `KEY_HOLD_DEFAULT` = 2_000_000.
- Sub-module `key_channel` contains one key's synchronizer, FSM, counters and strobes. `key_debouncer` instantiates it `N_KEYS` times in a generate loop.

## Test plan
The bench uses `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=10 and `N_KEYS`=2.
- Clean press: `key_raw[0]` rises and is held 20 cycles.
  - Expect `key_press[0]` high for exactly 1 cycle, 6 cycles after the rise.
  - Expect `key_level[0]` to become 1 in that same cycle.
  - Expect `key_release[0]` 6 cycles after `key_raw[0]` falls.
- Bounce rejection: `key_raw[0]` toggles 1,0,1,0 with each value held 2 cycles, then stays 0.
  - Expect no strobes and `key_level[0]`=0 throughout.
- Release bounce while pressed: with the key accepted, drop `key_raw[0]` for 3 cycles, then restore it.
  - Expect no `key_release` and `key_level[0]` to stay 1.
- Independence: press key 0 and key 1 with their rises 2 cycles apart.
  - Expect each `key_press` 6 cycles after its own rise.
  - Expect key 0's events to have no effect on key 1.
- Reset mid-debounce: assert `rst` 3 cycles after `key_raw[0]` rises while the key stays high.
  - Expect all outputs 0 immediately.
  - After `rst` falls, expect `key_press[0]` 6 cycles later.
- Long press, with `KEY_LONG_PRESS_EN` defined: hold the key 30 cycles.
  - Expect exactly one `key_long[0]` pulse, 10 cycles after `key_press[0]`.
  - Without the macro, expect `key_long` = 0 throughout.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key conditioning blocks.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int unsigned KEY_DEBOUNCE_DEFAULT = 32'd20_000;
    localparam int unsigned KEY_HOLD_DEFAULT     = 32'd2_000_000;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchronizer, debounce FSM, registered level/press/release strobes.
// Optional long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int unsigned HOLD_CYCLES     = KEY_HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw_i,
    output logic key_level_o,
    output logic key_press_o,
    output logic key_release_o,
    output logic key_long_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 32'd2 || HOLD_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
        $error("key_channel: need DEBOUNCE_CYCLES >= 2 and HOLD_CYCLES > DEBOUNCE_CYCLES");
    end

    logic [1:0]       sync_q;
    logic             key_sync;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    assign key_sync = sync_q[1];

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], key_raw_i};
        end
    end

    // Debounce next-state: a change is accepted only after DEBOUNCE_CYCLES stable samples.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            PRESS_WAIT: begin
                if (!key_sync) begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DOWN;
                    cnt_d   = CNT_ZERO;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            DOWN: begin
                if (!key_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            RELEASE_WAIT: begin
                if (key_sync) begin
                    state_d   = DOWN;
                    cnt_d     = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = CNT_ZERO;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              fired_q, fired_d;
    logic              long_q, long_d;

    // Hold counter spans DOWN and RELEASE_WAIT, so a short release bounce keeps the count;
    // fired_q makes the saturated count yield a single strobe per press.
    always_comb begin
        hold_d  = hold_q;
        fired_d = fired_q;
        long_d  = 1'b0;
        if (state_q == DOWN || state_q == RELEASE_WAIT) begin
            long_d = (hold_q == HOLD_LAST) && !fired_q;
            if (state_d == IDLE) begin
                hold_d  = HOLD_ZERO;
                fired_d = 1'b0;
            end else begin
                fired_d = fired_q | long_d;
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + HOLD_W'(1);
                end else begin
                    hold_d = hold_q;
                end
            end
        end else begin
            hold_d  = HOLD_ZERO;
            fired_d = 1'b0;
        end
    end

    // Long-press registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= HOLD_ZERO;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign key_long_o = long_q;
`else
    assign key_long_o = 1'b0;
`endif

endmodule

// File: rtl/key_debouncer.sv
// Multi-key push-button conditioner: N_KEYS independent key_channel instances.
// Long-press strobes exist only when KEY_LONG_PRESS_EN is defined.
module key_debouncer
    import key_pkg::*;
#(
    parameter int unsigned N_KEYS          = 32'd2,
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter int unsigned HOLD_CYCLES     = KEY_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES)
        ) u_channel (
            .clk           (clk),
            .rst           (rst),
            .key_raw_i     (key_raw[g]),
            .key_level_o   (key_level[g]),
            .key_press_o   (key_press[g]),
            .key_release_o (key_release[g]),
            .key_long_o    (key_long[g])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, N_KEYS=2.
// Inputs change on the falling edge; t counts falling edges since the change.
module tb_key_debouncer;

`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key_raw = 2'b00;
    logic [1:0] key_level, key_press, key_release, key_long;
    int         n_checks = 0;
    int         n_fail = 0;

    key_debouncer #(
        .N_KEYS          (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        key_raw = 2'b00;
        repeat (3) @(negedge clk);
        if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset outputs=%b expected 00000000", {key_level, key_press, key_release, key_long});
        end
        n_checks++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle outputs=%b expected 00000000", {key_level, key_press, key_release, key_long});
        end
        n_checks++;
    endtask

    task automatic test_clean_press();
        logic [1:0] el, ep, er, eg;
        for (int k = 0; k < 32; k++) begin
            key_raw = (k < 20) ? 2'b01 : 2'b00;
            @(negedge clk);
            el = {1'b0, (k + 1 >= 6) && (k + 1 < 26)};
            ep = {1'b0, (k + 1 == 6)};
            er = {1'b0, (k + 1 == 26)};
            eg = {1'b0, LONG_EN && (k + 1 == 16)};
            if (key_level !== el) begin n_fail++; $display("FAIL clean_level t=%0d got %b expected %b", k + 1, key_level, el); end
            if (key_press !== ep) begin n_fail++; $display("FAIL clean_press t=%0d got %b expected %b", k + 1, key_press, ep); end
            if (key_release !== er) begin n_fail++; $display("FAIL clean_release t=%0d got %b expected %b", k + 1, key_release, er); end
            if (key_long !== eg) begin n_fail++; $display("FAIL clean_long t=%0d got %b expected %b", k + 1, key_long, eg); end
            n_checks += 4;
        end
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 18; k++) begin
            key_raw = {1'b0, (k < 8) && (k % 4 < 2)};
            @(negedge clk);
            if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
                n_fail++;
                $display("FAIL bounce t=%0d outputs=%b expected 00000000", k + 1, {key_level, key_press, key_release, key_long});
            end
            n_checks++;
        end
    endtask

    task automatic test_release_bounce();
        logic [1:0] el, ep, er, eg;
        for (int k = 0; k < 36; k++) begin
            key_raw = {1'b0, (k < 8) || (k >= 11 && k < 24)};
            @(negedge clk);
            el = {1'b0, (k + 1 >= 6) && (k + 1 < 30)};
            ep = {1'b0, (k + 1 == 6)};
            er = {1'b0, (k + 1 == 30)};
            eg = {1'b0, LONG_EN && (k + 1 == 16)};
            if (key_level !== el) begin n_fail++; $display("FAIL relbounce_level t=%0d got %b expected %b", k + 1, key_level, el); end
            if (key_press !== ep) begin n_fail++; $display("FAIL relbounce_press t=%0d got %b expected %b", k + 1, key_press, ep); end
            if (key_release !== er) begin n_fail++; $display("FAIL relbounce_release t=%0d got %b expected %b", k + 1, key_release, er); end
            if (key_long !== eg) begin n_fail++; $display("FAIL relbounce_long t=%0d got %b expected %b", k + 1, key_long, eg); end
            n_checks += 4;
        end
    endtask

    task automatic test_independence();
        logic [1:0] el, ep, er, eg;
        for (int k = 0; k < 26; k++) begin
            key_raw = {(k >= 2) && (k < 14), (k < 14)};
            @(negedge clk);
            el = {(k + 1 >= 8) && (k + 1 < 20), (k + 1 >= 6) && (k + 1 < 20)};
            ep = {(k + 1 == 8), (k + 1 == 6)};
            er = {(k + 1 == 20), (k + 1 == 20)};
            eg = {LONG_EN && (k + 1 == 18), LONG_EN && (k + 1 == 16)};
            if (key_level !== el) begin n_fail++; $display("FAIL indep_level t=%0d got %b expected %b", k + 1, key_level, el); end
            if (key_press !== ep) begin n_fail++; $display("FAIL indep_press t=%0d got %b expected %b", k + 1, key_press, ep); end
            if (key_release !== er) begin n_fail++; $display("FAIL indep_release t=%0d got %b expected %b", k + 1, key_release, er); end
            if (key_long !== eg) begin n_fail++; $display("FAIL indep_long t=%0d got %b expected %b", k + 1, key_long, eg); end
            n_checks += 4;
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] el, ep, er;
        // Key 1 accepted first so the reset has a visible level to clear.
        for (int k = 0; k < 8; k++) begin
            key_raw = 2'b10;
            @(negedge clk);
            ep = {(k + 1 == 6), 1'b0};
            if (key_press !== ep) begin n_fail++; $display("FAIL rstmid_pre_press t=%0d got %b expected %b", k + 1, key_press, ep); end
            n_checks++;
        end
        if (key_level !== 2'b10) begin n_fail++; $display("FAIL rstmid_pre_level got %b expected 10", key_level); end
        n_checks++;
        key_raw = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        if ({key_level, key_press, key_release, key_long} !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_async outputs=%b expected 00000000", {key_level, key_press, key_release, key_long});
        end
        n_checks++;
        @(negedge clk);
        rst = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            ep = (t == 6) ? 2'b11 : 2'b00;
            el = (t >= 6) ? 2'b11 : 2'b00;
            if (key_press !== ep) begin n_fail++; $display("FAIL rstmid_press t=%0d got %b expected %b", t, key_press, ep); end
            if (key_level !== el) begin n_fail++; $display("FAIL rstmid_level t=%0d got %b expected %b", t, key_level, el); end
            n_checks += 2;
        end
        key_raw = 2'b00;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            er = (j == 6) ? 2'b11 : 2'b00;
            el = (j < 6) ? 2'b11 : 2'b00;
            if (key_release !== er) begin n_fail++; $display("FAIL rstmid_release j=%0d got %b expected %b", j, key_release, er); end
            if (key_level !== el) begin n_fail++; $display("FAIL rstmid_rel_level j=%0d got %b expected %b", j, key_level, el); end
            if (key_long !== 2'b00) begin n_fail++; $display("FAIL rstmid_long j=%0d got %b expected 00", j, key_long); end
            n_checks += 3;
        end
    endtask

    task automatic test_long_press();
        logic [1:0] el, ep, er, eg;
        for (int k = 0; k < 42; k++) begin
            key_raw = (k < 30) ? 2'b01 : 2'b00;
            @(negedge clk);
            el = {1'b0, (k + 1 >= 6) && (k + 1 < 36)};
            ep = {1'b0, (k + 1 == 6)};
            er = {1'b0, (k + 1 == 36)};
            eg = {1'b0, LONG_EN && (k + 1 == 16)};
            if (key_level !== el) begin n_fail++; $display("FAIL long_level t=%0d got %b expected %b", k + 1, key_level, el); end
            if (key_press !== ep) begin n_fail++; $display("FAIL long_press t=%0d got %b expected %b", k + 1, key_press, ep); end
            if (key_release !== er) begin n_fail++; $display("FAIL long_release t=%0d got %b expected %b", k + 1, key_release, er); end
            if (key_long !== eg) begin n_fail++; $display("FAIL long_strobe t=%0d got %b expected %b", k + 1, key_long, eg); end
            n_checks += 4;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_independence();
        test_reset_mid();
        test_long_press();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
